// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Entries carry the fetched word together with its PC.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of {pc, inst} entries.
// Head entry is read straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers and occupancy; flush empties the buffer in one edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage, contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited
// imem requests, response buffering and redirect flushing.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redir_pc;
    fetch_entry_t    wdata;
    fetch_entry_t    rdata;

    assign credit_ok = (int'(out_q) + int'(fifo_count)) < int'(FIFO_DEPTH);
    assign imem_req_valid = reset && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire = imem_req_valid && imem_req_ready;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    assign push  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop   = inst_valid && inst_ready;
    assign wdata = '{pc: rsp_pc_q, inst: imem_rsp_data};

    assign inst_valid = !fifo_empty;
    assign inst_data  = rdata.inst;
    assign inst_pc    = rdata.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .rdata_o (rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: advance PCs, track in-flight and to-be-dropped responses
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push) rsp_pc_d = rsp_pc_q + 32'd4;
        if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - 1'b1;
        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            drop_d     = out_d;
        end
    end

    // Fetch state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    a_out_bound: assert property (@(posedge clk) disable iff (!reset)
        int'(out_q) <= int'(FIFO_DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        int'(drop_q) <= int'(FIFO_DEPTH));

endmodule
